// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: FSM encodings, mode bit positions
// and the CPOL/CPHA edge selection helpers.
package spi_slave_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } spi_state_e;

    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    // Leading edge leaves the idle level; trailing edge returns to it.
    function automatic logic sample_edge_sel(input logic [1:0] mode,
                                             input logic rise, input logic fall);
        logic leading;
        logic trailing;
        leading  = mode[MODE_CPOL_BIT] ? fall : rise;
        trailing = mode[MODE_CPOL_BIT] ? rise : fall;
        return mode[MODE_CPHA_BIT] ? trailing : leading;
    endfunction

    function automatic logic shift_edge_sel(input logic [1:0] mode,
                                            input logic rise, input logic fall);
        logic leading;
        logic trailing;
        leading  = mode[MODE_CPOL_BIT] ? fall : rise;
        trailing = mode[MODE_CPOL_BIT] ? rise : fall;
        return mode[MODE_CPHA_BIT] ? leading : trailing;
    endfunction

endpackage

// File: rtl/spi_slave_port_if.sv
// Pin and host-side bundle of the SPI slave port; master drives the SPI pins
// and host controls, slave is the port itself.
interface spi_slave_port_if #(parameter int DATA_W = 8);

    logic              cpol_in;
    logic              cpha_in;
    logic              sclk_in;
    logic              ss_n_in;
    logic              mosi_in;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              rx_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              overrun;
    logic              miso_out;
    logic              miso_oe;
    logic              busy;

    modport master (
        output cpol_in, cpha_in, sclk_in, ss_n_in, mosi_in, tx_data, tx_load, rx_ack,
        input  rx_data, rx_valid, overrun, miso_out, miso_oe, busy
    );

    modport slave (
        input  cpol_in, cpha_in, sclk_in, ss_n_in, mosi_in, tx_data, tx_load, rx_ack,
        output rx_data, rx_valid, overrun, miso_out, miso_oe, busy
    );

endinterface

// File: rtl/spi_slave_port_sync_edge.sv
// Multi-stage synchronizer for an asynchronous SPI pin with rise/fall pulses
// derived from the synchronized level. STAGES must be at least 2.
module spi_slave_port_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // synchronizer chain plus one-cycle history for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint: oversampled SCLK/SS_N/MOSI, LSB-first, all CPOL/CPHA modes,
// host TX holding register and RX valid/ack handshake with overrun flag.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    spi_slave_port_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_e        state_r;
    spi_state_e        state_next_s;
    logic              sclk_s, sclk_rise_s, sclk_fall_s;
    logic              ss_n_s, ss_rise_s, ss_fall_s;
    logic              mosi_s, mosi_rise_s, mosi_fall_s;
    logic              unused_s;
    logic              start_s, complete_s, abort_s, sample_s, shift_s;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] rx_sr_r;
    logic [DATA_W-1:0] tx_sr_r;
    logic [DATA_W-1:0] tx_hold_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r, overrun_r, miso_r, miso_oe_r, busy_r;
    logic              skip_r, armed_r;

    // Reset value 0 on SS_N: a select already low when reset releases never
    // produces a falling edge, so no partial frame can start.
    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .CLK(CLK), .RST_N(RST_N), .d(bus.sclk_in),
        .q(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
        .CLK(CLK), .RST_N(RST_N), .d(bus.ss_n_in),
        .q(ss_n_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );

    spi_slave_port_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .CLK(CLK), .RST_N(RST_N), .d(bus.mosi_in),
        .q(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    assign unused_s = ^{sclk_s, ss_rise_s, mosi_rise_s, mosi_fall_s};

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_next_s = ST_ACTIVE;
                else         state_next_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (cnt_r == CNT_W'(DATA_W)) state_next_s = ST_DONE;
                else if (ss_n_s)             state_next_s = ST_IDLE;
                else                         state_next_s = ST_ACTIVE;
            end
            ST_DONE: begin
                if (ss_n_s) state_next_s = ST_IDLE;
                else        state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: frame events and qualified SCLK edges
    always_comb begin
        start_s    = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        sample_s   = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s && armed_r) start_s = 1'b1;
                else                      start_s = 1'b0;
            end
            ST_ACTIVE: begin
                if (cnt_r == CNT_W'(DATA_W)) begin
                    complete_s = 1'b1;
                end else if (ss_n_s) begin
                    abort_s = 1'b1;
                end else begin
                    sample_s = sample_edge_sel(mode_r, sclk_rise_s, sclk_fall_s);
                    shift_s  = shift_edge_sel(mode_r, sclk_rise_s, sclk_fall_s);
                end
            end
            ST_DONE: begin
                complete_s = 1'b0;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Shift datapath: mode latch, bit counter, RX/TX shift registers, MISO bit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r  <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
            rx_sr_r <= {DATA_W{1'b0}};
            tx_sr_r <= {DATA_W{1'b0}};
            miso_r  <= 1'b0;
            skip_r  <= 1'b0;
        end else if (start_s) begin
            mode_r[MODE_CPOL_BIT] <= bus.cpol_in;
            mode_r[MODE_CPHA_BIT] <= bus.cpha_in;
            cnt_r   <= {CNT_W{1'b0}};
            tx_sr_r <= tx_hold_r;
            miso_r  <= tx_hold_r[0];
            skip_r  <= bus.cpha_in;
        end else if (abort_s || complete_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (sample_s) begin
                rx_sr_r <= {mosi_s, rx_sr_r[DATA_W-1:1]};
                cnt_r   <= cnt_r + CNT_W'(1);
            end
            // With CPHA=1 bit0 is already driven, so the first shift edge is a no-op.
            if (shift_s) begin
                if (skip_r) begin
                    skip_r <= 1'b0;
                end else begin
                    tx_sr_r <= {1'b0, tx_sr_r[DATA_W-1:1]};
                    miso_r  <= tx_sr_r[1];
                end
            end
        end
    end

    // TX holding register, copied into the shifter only at frame start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_hold_r <= {DATA_W{1'b0}};
        end else if (bus.tx_load) begin
            tx_hold_r <= bus.tx_data;
        end else begin
            tx_hold_r <= tx_hold_r;
        end
    end

    // RX handshake; a completion beats a same-cycle acknowledge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_data_r  <= {DATA_W{1'b0}};
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            overrun_r <= complete_s & rx_valid_r & ~bus.rx_ack;
            if (complete_s) begin
                rx_data_r  <= rx_sr_r;
                rx_valid_r <= 1'b1;
            end else if (bus.rx_ack) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    // Arming after reset (select seen high) and registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_r   <= 1'b0;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            armed_r   <= armed_r | ss_n_s;
            miso_oe_r <= armed_r & ~ss_n_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.overrun  = overrun_r;
    assign bus.miso_out = miso_r;
    assign bus.miso_oe  = miso_oe_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a task-driven SPI master plus a scoreboard
// queue of expected RX bytes checked by an independent monitor.
module tb_spi_slave_port;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    spi_slave_port_if #(.DATA_W(8)) bus();

    spi_slave_port #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int         total = 0;
    int         bad = 0;
    int         ovr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       mon_prev_v = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half_wait();
        repeat (8) @(posedge CLK);
        #1;
    endtask

    task automatic load_tx(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        @(posedge CLK);
        #1;
        bus.tx_load = 1'b0;
    endtask

    // SPI master: nbits SCLK cycles, LSB-first, collects MISO at the sample edge
    task automatic frame(input logic cpol, input logic cpha, input logic [7:0] mo,
                         input int nbits, input bit chk, input logic [7:0] exp_miso);
        logic [7:0] mi;
        mi = 8'h00;
        bus.cpol_in = cpol;
        bus.cpha_in = cpha;
        bus.sclk_in = cpol;
        bus.ss_n_in = 1'b1;
        half_wait();
        if (!cpha) bus.mosi_in = mo[0];
        bus.ss_n_in = 1'b0;
        half_wait();
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                bus.sclk_in = ~cpol;
                mi[i] = bus.miso_out;
                half_wait();
                bus.sclk_in = cpol;
                if (i + 1 < nbits) bus.mosi_in = mo[i+1];
                half_wait();
            end else begin
                bus.sclk_in = ~cpol;
                bus.mosi_in = mo[i];
                half_wait();
                bus.sclk_in = cpol;
                mi[i] = bus.miso_out;
                half_wait();
            end
            if (chk && i == 0) check("miso_oe_in_frame", bus.miso_oe, 1'b1);
        end
        bus.ss_n_in = 1'b1;
        half_wait();
        half_wait();
        if (chk) begin
            check("miso_byte", mi, exp_miso);
            check("miso_oe_after", bus.miso_oe, 1'b0);
        end
    endtask

    task automatic ack_rx();
        int k;
        k = 0;
        while (!bus.rx_valid && k < 64) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("rx_valid_before_ack", bus.rx_valid, 1'b1);
        bus.rx_ack = 1'b1;
        @(posedge CLK);
        #1;
        bus.rx_ack = 1'b0;
        check("rx_valid_after_ack", bus.rx_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, bus.rx_data, 8'h00);
        check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check({tag, "_overrun"}, bus.overrun, 1'b0);
        check({tag, "_miso_out"}, bus.miso_out, 1'b0);
        check({tag, "_miso_oe"}, bus.miso_oe, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    // Reset mid-frame, roughly at bit 4 of a frame started together with this task
    task automatic reset_mid_frame();
        repeat (84) @(posedge CLK);
        #1;
        check("busy_before_rst", bus.busy, 1'b1);
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("busy_after_rst_ss_low", bus.busy, 1'b0);
        check("rx_valid_after_rst_ss_low", bus.rx_valid, 1'b0);
    endtask

    // Scoreboard monitor: every new or overwritten RX frame pops one expectation
    initial begin
        forever begin
            @(negedge CLK);
            if ((bus.rx_valid && !mon_prev_v) || bus.overrun) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", bus.rx_data, mon_exp);
                end
            end
            if (bus.overrun) ovr_cnt++;
            mon_prev_v = bus.rx_valid;
        end
    end

    initial begin
        int ovr0;
        bus.cpol_in = 1'b0;
        bus.cpha_in = 1'b0;
        bus.sclk_in = 1'b0;
        bus.ss_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        bus.rx_ack  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("idle_miso_oe", bus.miso_oe, 1'b0);
        check("idle_busy", bus.busy, 1'b0);

        // all four modes, same TX byte and MOSI byte
        load_tx(8'hA5);
        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = m[1:0];
            exp_q.push_back(8'h3C);
            frame(md[1], md[0], 8'h3C, 8, 1'b1, 8'hA5);
            ack_rx();
        end

        // short frame aborts, then a full frame
        frame(1'b0, 1'b0, 8'h55, 5, 1'b0, 8'h00);
        check("short_busy", bus.busy, 1'b0);
        check("short_rx_valid", bus.rx_valid, 1'b0);
        exp_q.push_back(8'h81);
        frame(1'b0, 1'b0, 8'h81, 8, 1'b1, 8'hA5);
        ack_rx();

        // two frames without acknowledge: one overrun, newest data kept
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        frame(1'b1, 1'b1, 8'h11, 8, 1'b1, 8'hA5);
        exp_q.push_back(8'h22);
        frame(1'b1, 1'b1, 8'h22, 8, 1'b1, 8'hA5);
        check("overrun_pulses", ovr_cnt - ovr0, 1);
        check("overrun_rx_data", bus.rx_data, 8'h22);
        ack_rx();

        // TX load during a frame only affects the following frame
        exp_q.push_back(8'h42);
        fork
            frame(1'b0, 1'b0, 8'h42, 8, 1'b1, 8'hA5);
            begin
                repeat (40) @(posedge CLK);
                #1;
                load_tx(8'hF0);
            end
        join
        ack_rx();
        exp_q.push_back(8'h24);
        frame(1'b0, 1'b1, 8'h24, 8, 1'b1, 8'hF0);
        ack_rx();

        // reset mid-frame with SS_N held low, then a clean frame
        fork
            frame(1'b0, 1'b0, 8'h99, 8, 1'b0, 8'h00);
            reset_mid_frame();
        join
        load_tx(8'h5A);
        exp_q.push_back(8'hC3);
        frame(1'b0, 1'b0, 8'hC3, 8, 1'b1, 8'h5A);
        ack_rx();

        repeat (5) @(posedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
